// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller and its datapath.
// Instruction fields and memory status in, control strobes out.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic [3:0] alu_control;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode, funct, mem_ready,
    output pc_write, pc_write_cond, ir_write,
    output reg_write, mem_read, mem_write,
    output i_or_d, reg_dst, mem_to_reg,
    output alu_src_a, alu_src_b, pc_source,
    output alu_control, state,
    output instr_done, illegal_op
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  pc_write, pc_write_cond, ir_write,
    input  reg_write, mem_read, mem_write,
    input  i_or_d, reg_dst, mem_to_reg,
    input  alu_src_a, alu_src_b, pc_source,
    input  alu_control, state,
    input  instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: lw/sw/R-type/beq/j/addi.
// All outputs are forced low while reset is high.
module multicycle_control (
  input  logic clk,
  input  logic reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t cur, nxt;
  logic [3:0] f_alu;
  logic       f_ok;

  always_ff @(posedge clk) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  always_comb begin
    f_alu = ALU_ADD;
    f_ok  = 1'b1;
    unique case (bus.funct)
      6'h20:   f_alu = ALU_ADD;
      6'h22:   f_alu = ALU_SUB;
      6'h24:   f_alu = ALU_AND;
      6'h25:   f_alu = ALU_OR;
      6'h2A:   f_alu = ALU_SLT;
      default: f_ok  = 1'b0;
    endcase
  end

  always_comb begin
    nxt               = cur;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.pc_source     = 2'b00;
    bus.alu_control   = ALU_ADD;
    bus.instr_done    = 1'b0;
    bus.illegal_op    = 1'b0;
    bus.state         = cur;
    unique case (cur)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          nxt          = DECODE;
        end
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        unique case (bus.opcode)
          OP_R: begin
            if (f_ok) nxt = EXECUTE;
            else begin
              nxt            = FETCH;
              bus.illegal_op = 1'b1;
            end
          end
          OP_LW, OP_SW: nxt = MEM_ADDR;
          OP_BEQ:       nxt = BRANCH;
          OP_J:         nxt = JUMP;
          OP_ADDI:      nxt = ADDI_EXEC;
          default: begin
            nxt            = FETCH;
            bus.illegal_op = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        nxt = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) nxt = MEM_WB;
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
        nxt            = FETCH;
      end
      MEM_WRITE: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          bus.instr_done = 1'b1;
          nxt            = FETCH;
        end
      end
      EXECUTE: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_control = f_alu;
        nxt             = R_WB;
      end
      R_WB: begin
        bus.reg_write   = 1'b1;
        bus.reg_dst     = 1'b1;
        bus.alu_control = f_alu;
        bus.instr_done  = 1'b1;
        nxt             = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_control   = ALU_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        bus.instr_done    = 1'b1;
        nxt               = FETCH;
      end
      JUMP: begin
        bus.pc_write   = 1'b1;
        bus.pc_source  = 2'b10;
        bus.instr_done = 1'b1;
        nxt            = FETCH;
      end
      ADDI_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        nxt           = ADDI_WB;
      end
      ADDI_WB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        nxt            = FETCH;
      end
      default: nxt = FETCH;
    endcase
    // reset aborts in-flight accesses in the same cycle
    if (reset) begin
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.ir_write      = 1'b0;
      bus.reg_write     = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.i_or_d        = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.pc_source     = 2'b00;
      bus.alu_control   = 4'b0000;
      bus.instr_done    = 1'b0;
      bus.illegal_op    = 1'b0;
      bus.state         = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control.
// Each step compares the full packed control word against a hand value.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  multicycle_control_if b ();

  multicycle_control u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b.master)
  );

  always #5 clk = ~clk;

  // enable order: pcw pcc irw rw mr mw iod rd m2r asa
  function automatic logic [23:0] ew(
    input logic [3:0] st,
    input logic [9:0] en,
    input logic [1:0] asb,
    input logic [1:0] ps,
    input logic [3:0] aluc,
    input logic       done,
    input logic       ill
  );
    return {st, en, asb, ps, aluc, done, ill};
  endfunction

  function automatic logic [23:0] obs();
    return {b.state,
            b.pc_write, b.pc_write_cond, b.ir_write,
            b.reg_write, b.mem_read, b.mem_write,
            b.i_or_d, b.reg_dst, b.mem_to_reg,
            b.alu_src_a, b.alu_src_b, b.pc_source,
            b.alu_control, b.instr_done, b.illegal_op};
  endfunction

  task automatic cyc(input string tag, input logic [23:0] e);
    logic [23:0] o;
    #1;
    o = obs();
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [23:0] F_RDY =
    ew(4'd0, 10'b1010100000, 2'b01, 2'b00, 4'b0010, 1'b0, 1'b0);
  localparam logic [23:0] F_WAIT =
    ew(4'd0, 10'b0000100000, 2'b01, 2'b00, 4'b0010, 1'b0, 1'b0);
  localparam logic [23:0] DEC =
    ew(4'd1, 10'b0000000000, 2'b11, 2'b00, 4'b0010, 1'b0, 1'b0);
  localparam logic [23:0] DEC_ILL =
    ew(4'd1, 10'b0000000000, 2'b11, 2'b00, 4'b0010, 1'b0, 1'b1);
  localparam logic [23:0] MADDR =
    ew(4'd2, 10'b0000000001, 2'b10, 2'b00, 4'b0010, 1'b0, 1'b0);
  localparam logic [23:0] MRD =
    ew(4'd3, 10'b0000101000, 2'b00, 2'b00, 4'b0010, 1'b0, 1'b0);
  localparam logic [23:0] MWB =
    ew(4'd4, 10'b0001000010, 2'b00, 2'b00, 4'b0010, 1'b1, 1'b0);
  localparam logic [23:0] MWR_W =
    ew(4'd5, 10'b0000011000, 2'b00, 2'b00, 4'b0010, 1'b0, 1'b0);
  localparam logic [23:0] MWR_D =
    ew(4'd5, 10'b0000011000, 2'b00, 2'b00, 4'b0010, 1'b1, 1'b0);
  localparam logic [23:0] EX_SLT =
    ew(4'd6, 10'b0000000001, 2'b00, 2'b00, 4'b0111, 1'b0, 1'b0);
  localparam logic [23:0] RWB_SLT =
    ew(4'd7, 10'b0001000100, 2'b00, 2'b00, 4'b0111, 1'b1, 1'b0);
  localparam logic [23:0] EX_SUB =
    ew(4'd6, 10'b0000000001, 2'b00, 2'b00, 4'b0110, 1'b0, 1'b0);
  localparam logic [23:0] BR =
    ew(4'd8, 10'b0100000001, 2'b00, 2'b01, 4'b0110, 1'b1, 1'b0);
  localparam logic [23:0] JMP =
    ew(4'd9, 10'b1000000000, 2'b00, 2'b10, 4'b0010, 1'b1, 1'b0);
  localparam logic [23:0] AEX =
    ew(4'd10, 10'b0000000001, 2'b10, 2'b00, 4'b0010, 1'b0, 1'b0);
  localparam logic [23:0] AWB =
    ew(4'd11, 10'b0001000000, 2'b00, 2'b00, 4'b0010, 1'b1, 1'b0);

  initial begin
    reset       = 1'b1;
    b.opcode    = 6'h00;
    b.funct     = 6'h20;
    b.mem_ready = 1'b1;
    cyc("reset_zero", 24'h0);
    reset = 1'b0;

    // lw: 5 cycles
    b.opcode = 6'h23;
    cyc("lw_fetch", F_RDY);
    cyc("lw_decode", DEC);
    cyc("lw_addr", MADDR);
    cyc("lw_read", MRD);
    cyc("lw_wb", MWB);

    // R-type slt, with two FETCH wait cycles first
    b.opcode    = 6'h00;
    b.funct     = 6'h2A;
    b.mem_ready = 1'b0;
    cyc("r_fetch_wait0", F_WAIT);
    cyc("r_fetch_wait1", F_WAIT);
    b.mem_ready = 1'b1;
    cyc("r_fetch", F_RDY);
    cyc("r_decode", DEC);
    cyc("r_exec_slt", EX_SLT);
    cyc("r_wb_slt", RWB_SLT);

    // sw with 3 wait cycles in MEM_WRITE: 7 cycles
    b.opcode = 6'h2B;
    cyc("sw_fetch", F_RDY);
    cyc("sw_decode", DEC);
    cyc("sw_addr", MADDR);
    b.mem_ready = 1'b0;
    cyc("sw_wr_wait0", MWR_W);
    cyc("sw_wr_wait1", MWR_W);
    cyc("sw_wr_wait2", MWR_W);
    b.mem_ready = 1'b1;
    cyc("sw_wr_done", MWR_D);

    // beq then j
    b.opcode = 6'h04;
    cyc("beq_fetch", F_RDY);
    cyc("beq_decode", DEC);
    cyc("beq_branch", BR);
    b.opcode = 6'h02;
    cyc("j_fetch", F_RDY);
    cyc("j_decode", DEC);
    cyc("j_jump", JMP);

    // addi
    b.opcode = 6'h08;
    cyc("addi_fetch", F_RDY);
    cyc("addi_decode", DEC);
    cyc("addi_exec", AEX);
    cyc("addi_wb", AWB);

    // illegal opcode
    b.opcode = 6'h3F;
    cyc("ill_op_fetch", F_RDY);
    cyc("ill_op_decode", DEC_ILL);

    // illegal funct
    b.opcode = 6'h00;
    b.funct  = 6'h07;
    cyc("ill_fn_fetch", F_RDY);
    cyc("ill_fn_decode", DEC_ILL);

    // sub R-type after an illegal: decoder recovers
    b.funct = 6'h22;
    cyc("sub_fetch", F_RDY);
    cyc("sub_decode", DEC);
    cyc("sub_exec", EX_SUB);
    b.funct = 6'h2A;

    // reset mid MEM_WRITE with mem_ready low
    b.opcode = 6'h2B;
    cyc("rst_prior_wb", RWB_SLT);
    cyc("rst_fetch", F_RDY);
    cyc("rst_decode", DEC);
    cyc("rst_addr", MADDR);
    b.mem_ready = 1'b0;
    cyc("rst_wr_wait", MWR_W);
    reset = 1'b1;
    cyc("rst_zero", 24'h0);
    reset       = 1'b0;
    b.mem_ready = 1'b1;
    cyc("rst_refetch", F_RDY);
    cyc("rst_redecode", DEC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
